matrix3x3_rinv_qt_multiply: RTL and testbench

Completes the QR-based 3x3 inverse, A⁻¹ = R⁻¹·Qᵀ. It consumes the upper-triangular R⁻¹ produced by the triangular inverter and the orthogonal Q from the decomposition stage, and produces all nine A⁻¹ elements. A single shared multiply-accumulate unit walks a fixed 18-step schedule that skips the structural zeros of R⁻¹. The block sits directly downstream of the inverter and uses the same start/done handshake.

---
 rtl/rinv_qt_pkg.sv | 31 +++
 rtl/fixed_point_mac.sv | 63 ++++++
 rtl/matrix3x3_rinv_qt_multiply.sv | 127 ++++++++++++
 tb/tb_matrix3x3_rinv_qt_multiply.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rinv_qt_pkg.sv
// Shared types and the fixed 18-step MAC schedule for the R^-1 * Q^T multiplier.
package rinv_qt_pkg;

    localparam int DEFAULT_WORD_LENGTH     = 16;
    localparam int DEFAULT_FRACTION_LENGTH = 12;
    localparam int STEPS                   = 18;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
        logic [1:0] k;
        logic       last;
    } sched_t;

    // Column-major walk; each row only visits k >= row, skipping R^-1's zeros.
    localparam sched_t SCHEDULE [STEPS] = '{
        '{2'd0, 2'd0, 2'd0, 1'b0}, '{2'd0, 2'd0, 2'd1, 1'b0}, '{2'd0, 2'd0, 2'd2, 1'b1},
        '{2'd1, 2'd0, 2'd1, 1'b0}, '{2'd1, 2'd0, 2'd2, 1'b1}, '{2'd2, 2'd0, 2'd2, 1'b1},
        '{2'd0, 2'd1, 2'd0, 1'b0}, '{2'd0, 2'd1, 2'd1, 1'b0}, '{2'd0, 2'd1, 2'd2, 1'b1},
        '{2'd1, 2'd1, 2'd1, 1'b0}, '{2'd1, 2'd1, 2'd2, 1'b1}, '{2'd2, 2'd1, 2'd2, 1'b1},
        '{2'd0, 2'd2, 2'd0, 1'b0}, '{2'd0, 2'd2, 2'd1, 1'b0}, '{2'd0, 2'd2, 2'd2, 1'b1},
        '{2'd1, 2'd2, 2'd1, 1'b0}, '{2'd1, 2'd2, 2'd2, 1'b1}, '{2'd2, 2'd2, 2'd2, 1'b1}
    };

endpackage

// File: rtl/fixed_point_mac.sv
// Signed multiply-accumulate with round/shift/saturate write-back value.
// Macro RINV_QT_ROUND_EN selects round-half-up instead of truncation.
module fixed_point_mac
    import rinv_qt_pkg::*;
#(
    parameter int wordLength     = DEFAULT_WORD_LENGTH,
    parameter int fractionLength = DEFAULT_FRACTION_LENGTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         en,
    input  logic                         last,
    input  logic signed [wordLength-1:0] a,
    input  logic signed [wordLength-1:0] b,
    output logic signed [wordLength-1:0] result
);

    localparam int PROD_W = 2 * wordLength;
    localparam int ACC_W  = 2 * wordLength + 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - wordLength + 1){1'b0}}, {(wordLength - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - wordLength + 1){1'b1}}, {(wordLength - 1){1'b0}}};

    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  biased;
    logic signed [ACC_W-1:0]  shifted;

    assign product = PROD_W'(a) * PROD_W'(b);
    assign sum     = acc + ACC_W'(product);

`ifdef RINV_QT_ROUND_EN
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) <<< (fractionLength - 1);
    assign biased = sum + ROUND_BIAS;
`else
    assign biased = sum;
`endif

    assign shifted = biased >>> fractionLength;

    always_comb begin
        result = shifted[wordLength-1:0];
        if (shifted > SAT_MAX) begin
            result = {1'b0, {(wordLength - 1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            result = {1'b1, {(wordLength - 1){1'b0}}};
        end
    end

    // The accumulator self-clears after each element's final term.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= last ? '0 : sum;
        end
    end

endmodule

// File: rtl/matrix3x3_rinv_qt_multiply.sv
// A^-1 = R^-1 * Q^T using one shared MAC over a fixed 18-step schedule.
// Build option RINV_QT_ROUND_EN (in fixed_point_mac) enables rounding.
module matrix3x3_rinv_qt_multiply
    import rinv_qt_pkg::*;
#(
    parameter int wordLength     = DEFAULT_WORD_LENGTH,
    parameter int fractionLength = DEFAULT_FRACTION_LENGTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [wordLength-1:0] R11_inv,
    input  logic signed [wordLength-1:0] R12_inv,
    input  logic signed [wordLength-1:0] R13_inv,
    input  logic signed [wordLength-1:0] R22_inv,
    input  logic signed [wordLength-1:0] R23_inv,
    input  logic signed [wordLength-1:0] R33_inv,
    input  logic signed [wordLength-1:0] Q11,
    input  logic signed [wordLength-1:0] Q12,
    input  logic signed [wordLength-1:0] Q13,
    input  logic signed [wordLength-1:0] Q21,
    input  logic signed [wordLength-1:0] Q22,
    input  logic signed [wordLength-1:0] Q23,
    input  logic signed [wordLength-1:0] Q31,
    input  logic signed [wordLength-1:0] Q32,
    input  logic signed [wordLength-1:0] Q33,
    output logic signed [wordLength-1:0] A11,
    output logic signed [wordLength-1:0] A12,
    output logic signed [wordLength-1:0] A13,
    output logic signed [wordLength-1:0] A21,
    output logic signed [wordLength-1:0] A22,
    output logic signed [wordLength-1:0] A23,
    output logic signed [wordLength-1:0] A31,
    output logic signed [wordLength-1:0] A32,
    output logic signed [wordLength-1:0] A33,
    output logic                         busy,
    output logic                         done
);

    state_t state, state_next;
    logic [4:0] step;
    sched_t sched;
    logic capture;
    logic mac_en;
    logic signed [wordLength-1:0] mac_result;

    // Lower triangle of rinv_r is never written and stays zero.
    logic signed [wordLength-1:0] rinv_r [3][3];
    logic signed [wordLength-1:0] q_r    [3][3];
    logic signed [wordLength-1:0] a_r    [3][3];

    assign sched   = SCHEDULE[step];
    assign capture = (state == IDLE) && start;
    assign mac_en  = (state == MAC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (step == 5'(STEPS - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    fixed_point_mac #(
        .wordLength     (wordLength),
        .fractionLength (fractionLength)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (capture),
        .en     (mac_en),
        .last   (sched.last),
        .a      (rinv_r[sched.row][sched.k]),
        .b      (q_r[sched.col][sched.k]),
        .result (mac_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            step <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    rinv_r[i][j] <= '0;
                    q_r[i][j]    <= '0;
                    a_r[i][j]    <= '0;
                end
            end
        end else begin
            if (capture) begin
                step         <= '0;
                rinv_r[0][0] <= R11_inv;
                rinv_r[0][1] <= R12_inv;
                rinv_r[0][2] <= R13_inv;
                rinv_r[1][1] <= R22_inv;
                rinv_r[1][2] <= R23_inv;
                rinv_r[2][2] <= R33_inv;
                q_r[0][0] <= Q11; q_r[0][1] <= Q12; q_r[0][2] <= Q13;
                q_r[1][0] <= Q21; q_r[1][1] <= Q22; q_r[1][2] <= Q23;
                q_r[2][0] <= Q31; q_r[2][1] <= Q32; q_r[2][2] <= Q33;
            end
            if (mac_en) begin
                step <= (step == 5'(STEPS - 1)) ? '0 : step + 5'd1;
                if (sched.last) begin
                    a_r[sched.row][sched.col] <= mac_result;
                end
            end
        end
    end

    assign A11 = a_r[0][0]; assign A12 = a_r[0][1]; assign A13 = a_r[0][2];
    assign A21 = a_r[1][0]; assign A22 = a_r[1][1]; assign A23 = a_r[1][2];
    assign A31 = a_r[2][0]; assign A32 = a_r[2][1]; assign A33 = a_r[2][2];

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_matrix3x3_rinv_qt_multiply.sv
// Randomized and directed bench for matrix3x3_rinv_qt_multiply against a
// plain-arithmetic model of A[i][j] = sum_k Rinv[i][k] * Q[j][k].
module tb_matrix3x3_rinv_qt_multiply;

    localparam int W = 16;
    localparam int F = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start;
    logic [W-1:0] R11_inv, R12_inv, R13_inv, R22_inv, R23_inv, R33_inv;
    logic [W-1:0] Q11, Q12, Q13, Q21, Q22, Q23, Q31, Q32, Q33;
    logic [W-1:0] A11, A12, A13, A21, A22, A23, A31, A32, A33;
    logic busy, done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] r_in  [6];
    logic [W-1:0] q_in  [9];
    logic [W-1:0] exp_a [9];
    logic [W-1:0] a_obs [9];

    assign a_obs[0] = A11; assign a_obs[1] = A12; assign a_obs[2] = A13;
    assign a_obs[3] = A21; assign a_obs[4] = A22; assign a_obs[5] = A23;
    assign a_obs[6] = A31; assign a_obs[7] = A32; assign a_obs[8] = A33;

    matrix3x3_rinv_qt_multiply dut (
        .clk(clk), .reset(reset), .start(start),
        .R11_inv(R11_inv), .R12_inv(R12_inv), .R13_inv(R13_inv),
        .R22_inv(R22_inv), .R23_inv(R23_inv), .R33_inv(R33_inv),
        .Q11(Q11), .Q12(Q12), .Q13(Q13),
        .Q21(Q21), .Q22(Q22), .Q23(Q23),
        .Q31(Q31), .Q32(Q32), .Q33(Q33),
        .A11(A11), .A12(A12), .A13(A13),
        .A21(A21), .A22(A22), .A23(A23),
        .A31(A31), .A32(A32), .A33(A33),
        .busy(busy), .done(done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        R11_inv = r_in[0]; R12_inv = r_in[1]; R13_inv = r_in[2];
        R22_inv = r_in[3]; R23_inv = r_in[4]; R33_inv = r_in[5];
        Q11 = q_in[0]; Q12 = q_in[1]; Q13 = q_in[2];
        Q21 = q_in[3]; Q22 = q_in[4]; Q23 = q_in[5];
        Q31 = q_in[6]; Q32 = q_in[7]; Q33 = q_in[8];
    endtask

    task automatic scramblePorts();
        {R11_inv, R12_inv, R13_inv} = {3{W'($urandom)}};
        {R22_inv, R23_inv, R33_inv} = {3{W'($urandom)}};
        {Q11, Q12, Q13, Q21, Q22} = {5{W'($urandom)}};
        {Q23, Q31, Q32, Q33} = {4{W'($urandom)}};
    endtask

    function automatic longint rinvAt(int i, int k);
        int idx;
        if (k < i) return 0;
        idx = (i == 0) ? k : (i == 1) ? (k + 2) : 5;
        return longint'($signed(r_in[idx]));
    endfunction

    task automatic computeModel();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                longint s = 0;
                for (int k = 0; k < 3; k++) begin
                    s += rinvAt(i, k) * longint'($signed(q_in[j * 3 + k]));
                end
`ifdef RINV_QT_ROUND_EN
                s += longint'(1) << (F - 1);
`endif
                s = s >>> F;
                if (s > 32767) s = 32767;
                else if (s < -32768) s = -32768;
                exp_a[i * 3 + j] = W'(s);
            end
        end
    endtask

    task automatic checkAll(input string tag);
        for (int idx = 0; idx < 9; idx++) begin
            checkOutput($sformatf("%s_A%0d%0d", tag, idx / 3 + 1, idx % 3 + 1),
                        32'(a_obs[idx]), 32'(exp_a[idx]));
        end
    endtask

    task automatic setIdentity(input logic [W-1:0] diag);
        r_in = '{diag, 16'h0, 16'h0, diag, 16'h0, diag};
        q_in = '{16'h1000, 16'h0, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h1000};
    endtask

    // Single start pulse; optionally a second ignored pulse at MAC cycle extra_at.
    task automatic runOp(input string tag, input int extra_at);
        int cnt;
        logic seen;
        applyStimulus();
        computeModel();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        scramblePorts();
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 40 && !seen) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (done) seen = 1'b1;
            start = (cnt == extra_at);
        end
        start = 1'b0;
        checkOutput({tag, "_latency"}, 32'(cnt), 32'd18);
        checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        checkAll(tag);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt;
        logic seen, stable;

        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) r_in[i] = '0;
        for (int i = 0; i < 9; i++) begin q_in[i] = '0; exp_a[i] = '0; end
        applyStimulus();
        repeat (3) @(negedge clk);
        checkAll("reset");
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        setIdentity(16'h1000);
        runOp("identity", -1);

        r_in = '{16'h2000, 16'h0, 16'h0, 16'h2000, 16'h0, 16'h2000};
        q_in = '{16'h0, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h1000, 16'h1000, 16'h0, 16'h0};
        runOp("perm", -1);

        for (int i = 0; i < 6; i++) r_in[i] = 16'h7FFF;
        for (int i = 0; i < 9; i++) q_in[i] = 16'h7FFF;
        runOp("sat_pos", -1);

        for (int i = 0; i < 9; i++) q_in[i] = 16'h8000;
        runOp("sat_neg", -1);

        for (int i = 0; i < 6; i++) r_in[i] = '0;
        for (int i = 0; i < 9; i++) q_in[i] = '0;
        r_in[0] = 16'h0001;
        q_in[0] = 16'h0800;
        runOp("round", -1);

        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 6; i++)
                r_in[i] = (n % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 16'h2000) - 16'h1000);
            for (int i = 0; i < 9; i++)
                q_in[i] = (n % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 16'h2000) - 16'h1000);
            runOp($sformatf("rand%0d", n), -1);
        end

        // Abort mid-operation with reset.
        for (int i = 0; i < 6; i++) r_in[i] = W'($urandom_range(16'h0400, 16'h1000));
        for (int i = 0; i < 9; i++) q_in[i] = W'($urandom_range(16'h0400, 16'h1000));
        applyStimulus();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) exp_a[i] = '0;
        checkAll("abort");
        checkOutput("abort_busy", 32'(busy), 32'd0);
        seen = done;
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("abort_no_done", 32'(seen), 32'd0);

        setIdentity(16'h1000);
        runOp("post_abort", -1);
        setIdentity(16'h1000);
        runOp("extra_start", 5);

        // Back-to-back with start held high.
        setIdentity(16'h1000);
        applyStimulus();
        computeModel();
        start = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 60 && !seen) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            seen = done;
        end
        checkOutput("b2b_first_latency", 32'(cnt), 32'd19);
        checkAll("b2b_1");
        for (int p = 2; p <= 3; p++) begin
            cnt    = 0;
            seen   = 1'b0;
            stable = 1'b1;
            while (cnt < 60 && !seen) begin
                @(posedge clk);
                cnt++;
                @(negedge clk);
                if (done) seen = 1'b1;
                for (int idx = 0; idx < 9; idx++)
                    if (a_obs[idx] !== exp_a[idx]) stable = 1'b0;
            end
            checkOutput($sformatf("b2b_interval%0d", p), 32'(cnt), 32'd20);
            checkOutput($sformatf("b2b_stable%0d", p), 32'(stable), 32'd1);
        end
        start = 1'b0;
        repeat (25) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
